// File: rtl/udp_tx_buffer.sv
// udp_tx_buffer: ping-pong sample buffer that feeds a UDP transmitter.
// Two banks of DEPTH 32-bit words. The sample side fills one bank while the
// transmitter reads the other through a registered, always-valid read port.
// Optional macro UDP_TXBUF_DROP_EN: sample_ready is tied high, and samples that
// arrive while the write bank is busy are dropped and counted in overflow_cnt.
module udp_tx_buffer #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_valid,
    input  logic [31:0]       sample_data,
    output logic              sample_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [31:0]       rd_data,
    input  logic              sendstart,
    input  logic              sendend,
    output logic              senden,
    output logic [3:0]        bank_state,
    output logic [15:0]       overflow_cnt
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2,
        SENDING = 2'd3
    } bank_t;

    // Both banks live in one array; the MSB of the address selects the bank.
    logic [31:0]      mem [2*DEPTH];

    bank_t            state_reg [2];
    bank_t            state_next [2];
    logic             wb_reg, wb_next;
    logic             rb_reg, rb_next;
    logic [IDX_W-1:0] wcnt_reg, wcnt_next;
    logic             sendstart_reg;
    logic             writable;
    logic             wr_en;
    logic [IDX_W-1:0] rd_idx;

    // The transmitter addresses words from 1, so rd_addr=1 maps to word 0.
    assign rd_idx = rd_addr[IDX_W-1:0] - IDX_W'(1);

    generate
        if (ADDR_W > IDX_W) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^rd_addr[ADDR_W-1:IDX_W];
        end
    endgenerate

    assign writable = (state_reg[wb_reg] == EMPTY) || (state_reg[wb_reg] == FILLING);
    assign wr_en    = sample_valid && writable;
    assign senden   = (state_reg[rb_reg] == FULL) || (state_reg[rb_reg] == SENDING);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank_state
            assign bank_state[2*gi +: 2] = state_reg[gi];
        end
    endgenerate

`ifdef UDP_TXBUF_DROP_EN
    logic [15:0] overflow_reg;

    assign sample_ready = 1'b1;
    assign overflow_cnt = overflow_reg;

    // Count samples dropped because the write bank is still full or sending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_reg <= '0;
        end else if (sample_valid && !writable && (overflow_reg != 16'hFFFF)) begin
            overflow_reg <= overflow_reg + 16'd1;
        end
    end
`else
    assign sample_ready = writable;
    assign overflow_cnt = '0;
`endif

    // Bank RAM write port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wb_reg, wcnt_reg}] <= sample_data;
        end
    end

    // Registered read port; a same-cycle write to the same word returns old data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[{rb_reg, rd_idx}];
        end
    end

    // Bank state, pointers, write counter and sendstart edge detector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg[0]  <= EMPTY;
            state_reg[1]  <= EMPTY;
            wb_reg        <= 1'b0;
            rb_reg        <= 1'b0;
            wcnt_reg      <= '0;
            sendstart_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wb_reg        <= wb_next;
            rb_reg        <= rb_next;
            wcnt_reg      <= wcnt_next;
            sendstart_reg <= sendstart;
        end
    end

    // Next-state logic. A write only touches a bank that is EMPTY/FILLING and the
    // send controls only touch a bank that is FULL/SENDING, so the two sides can
    // act in the same cycle without contending for a bank.
    always_comb begin
        state_next = state_reg;
        wb_next    = wb_reg;
        rb_next    = rb_reg;
        wcnt_next  = wcnt_reg;

        if (wr_en) begin
            if (wcnt_reg == IDX_W'(DEPTH - 1)) begin
                state_next[wb_reg] = FULL;
                wcnt_next          = '0;
                wb_next            = ~wb_reg;
            end else begin
                state_next[wb_reg] = FILLING;
                wcnt_next          = wcnt_reg + IDX_W'(1);
            end
        end

        if (sendstart && !sendstart_reg && (state_reg[rb_reg] == FULL)) begin
            state_next[rb_reg] = SENDING;
        end

        if (sendend && ((state_reg[rb_reg] == FULL) || (state_reg[rb_reg] == SENDING))) begin
            state_next[rb_reg] = EMPTY;
            rb_next            = ~rb_reg;
        end
    end

endmodule
